// File: rtl/nibble_serial_adder_pkg.sv
// adder_pkg: shared definitions for the nibble-serial adder.
//   NIB_W   : width of one slice processed per RUN cycle.
//   state_t : controller states (IDLE, RUN, DONE).
package adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result bundle for nibble_serial_adder.
//   in_valid/in_ready   : operand handshake (A, B, Cin)
//   out_valid/out_ready : result handshake (Sum)
//   busy                : controller is not IDLE
//
// Handshake rule (both directions): a transfer happens on a rising clk edge
// where valid && ready. The producer holds its payload stable while valid is
// high and ready is low; ready never depends combinationally on valid.
interface nibble_serial_adder_if
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [NIB_W*NIBBLES-1:0] A;
  logic [NIB_W*NIBBLES-1:0] B;
  logic                     Cin;
  logic                     out_valid;
  logic                     out_ready;
  logic [NIB_W*NIBBLES:0]   Sum;
  logic                     busy;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, busy
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, busy
  );

endinterface

// File: rtl/nibble_serial_adder_nibble_adder.sv
// nibble_adder: 4-bit combinational ripple-carry adder made of full-adder cells.
//   a, b : 4-bit addends
//   ci   : carry-in
//   s    : 4-bit sum
//   co   : carry-out of bit 3
module nibble_adder
  import adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W:0] carry;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = ci;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign co = carry[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two NIBBLES*4-bit unsigned operands plus a
// carry-in, one nibble per clock, reusing a single nibble_adder.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   bus   : slave side of nibble_serial_adder_if (operands, result, busy)
//   state : controller state, exported for observation
// Latency is NIBBLES cycles from the accept edge to out_valid; one operation
// is in flight at a time and operands offered outside IDLE are ignored.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_adder_if.slave        bus,
  output state_t                      state
);

  localparam int OP_W  = NIB_W * NIBBLES;
  localparam int SUM_W = OP_W + 1;
  localparam int CNT_W = $clog2(NIBBLES);

  state_t            next_state;
  logic [OP_W-1:0]   a_reg;
  logic [OP_W-1:0]   b_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic [CNT_W-1:0]  cnt;
  logic              c;
  logic              last;
  logic [31:0]       base;
  logic [NIB_W-1:0]  nib_s;
  logic              nib_co;

  assign last = (cnt == CNT_W'(NIBBLES - 1));
  // Bit offset of the nibble currently being processed.
  assign base = 32'(cnt) * 32'(NIB_W);

  nibble_adder u_nibble_adder (
    .a  (a_reg[base +: NIB_W]),
    .b  (b_reg[base +: NIB_W]),
    .ci (c),
    .s  (nib_s),
    .co (nib_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid)  next_state = RUN;
      RUN:     if (last)          next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, per-nibble accumulation, final carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      cnt     <= '0;
      c       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg   <= bus.A;
            b_reg   <= bus.B;
            c       <= bus.Cin;
            cnt     <= '0;
            sum_reg <= '0;
          end
        end
        RUN: begin
          sum_reg[base +: NIB_W] <= nib_s;
          c                      <= nib_co;
          // cnt parks at NIBBLES-1 on the last slice so it never overruns.
          if (last) sum_reg[SUM_W-1] <= nib_co;
          else      cnt              <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.Sum       = sum_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  import adder_pkg::*;

  localparam int SW  = 17;
  localparam int SW2 = 9;

  logic clk;
  logic rst;
  state_t st4;
  state_t st2;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] exp_q[$];

  nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_adder_if #(.NIBBLES(2)) bus2 ();

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus4),
    .state (st4)
  );

  nibble_serial_adder #(.NIBBLES(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus2),
    .state (st2)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the plain arithmetic sum.
  function automatic logic [SW-1:0] model4(input logic [15:0] a, input logic [15:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {16'd0, ci};
  endfunction

  function automatic logic [SW2-1:0] model2(input logic [7:0] a, input logic [7:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {8'd0, ci};
  endfunction

  // Driver: called just after a negedge, returns just after the negedge that
  // follows the accept edge. keep_valid leaves in_valid high with junk operands.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input bit keep_valid);
    int w = 0;
    while (!bus4.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("in_ready_timeout", 64'(w), 64'd0);
    bus4.A        = a;
    bus4.B        = b;
    bus4.Cin      = ci;
    bus4.in_valid = 1'b1;
    exp_q.push_back(model4(a, b, ci));
    @(negedge clk);
    if (keep_valid) begin
      bus4.A   = 16'hAAAA;
      bus4.B   = 16'h5555;
      bus4.Cin = 1'b0;
    end else begin
      bus4.in_valid = 1'b0;
    end
  endtask

  // Waits for the result, checks latency and value, holds out_ready low for
  // `hold` cycles, then releases and checks the return to IDLE.
  task automatic wait_result(input string tag, input int hold);
    int lat = 0;
    logic [SW-1:0] exp;
    while (!bus4.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_sum"}, 64'(bus4.Sum), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      bus4.out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(bus4.out_valid), 64'd1);
      check({tag, "_hold_sum"}, 64'(bus4.Sum), 64'(exp));
      check({tag, "_hold_busy"}, 64'(bus4.busy), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(bus4.in_ready), 64'd0);
    end
    bus4.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_released_valid"}, 64'(bus4.out_valid), 64'd0);
    check({tag, "_released_in_ready"}, 64'(bus4.in_ready), 64'd1);
  endtask

  task automatic run2(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int lat = 0;
    bus2.A        = a;
    bus2.B        = b;
    bus2.Cin      = ci;
    bus2.in_valid = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    while (!bus2.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("n2_latency", 64'(lat), 64'd2);
    check("n2_sum", 64'(bus2.Sum), 64'(model2(a, b, ci)));
    @(negedge clk);
    check("n2_released_in_ready", 64'(bus2.in_ready), 64'd1);
  endtask

  initial begin
    rst            = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.A         = '0;
    bus4.B         = '0;
    bus4.Cin       = 1'b0;
    bus4.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.A         = '0;
    bus2.B         = '0;
    bus2.Cin       = 1'b0;
    bus2.out_ready = 1'b1;

    @(negedge clk);
    check("rst_state", 64'(st4), 64'(IDLE));
    check("rst_in_ready", 64'(bus4.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus4.out_valid), 64'd0);
    check("rst_busy", 64'(bus4.busy), 64'd0);
    check("rst_sum", 64'(bus4.Sum), 64'd0);
    check("rst_n2_in_ready", 64'(bus2.in_ready), 64'd1);
    rst = 1'b0;

    // First accept on the first edge after reset release; carry out of nibble 1.
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    check("first_accept_busy", 64'(bus4.busy), 64'd1);
    wait_result("ff_plus_1", 0);

    // Carry ripples through every nibble into the top bit.
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_result("all_ones", 0);

    // Back-pressure: result held for 5 cycles.
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_result("backpressure", 5);

    // Operands offered during RUN are ignored; the held request is taken
    // on the edge after DONE->IDLE.
    start_op(16'h0F0F, 16'h0101, 1'b1, 1'b1);
    wait_result("ignored_during_run", 0);
    exp_q.push_back(model4(16'hAAAA, 16'h5555, 1'b0));
    @(negedge clk);
    check("second_accept_busy", 64'(bus4.busy), 64'd1);
    bus4.in_valid = 1'b0;
    wait_result("second_op", 0);

    // Reset during RUN with cnt == 2.
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_sum", 64'(bus4.Sum), 64'd0);
    check("midrun_rst_valid", 64'(bus4.out_valid), 64'd0);
    check("midrun_rst_in_ready", 64'(bus4.in_ready), 64'd1);
    check("midrun_rst_busy", 64'(bus4.busy), 64'd0);
    exp_q = {};
    @(negedge clk);
    rst = 1'b0;
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_result("after_reset", 0);

    // Reset while holding a result in DONE.
    start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("done_before_rst", 64'(bus4.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("done_rst_valid", 64'(bus4.out_valid), 64'd0);
    check("done_rst_sum", 64'(bus4.Sum), 64'd0);
    exp_q = {};
    @(negedge clk);
    rst = 1'b0;
    bus4.out_ready = 1'b1;

    // Randomized operations with random back-pressure.
    for (int n = 0; n < 25; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      start_op(ra, rb, rc, 1'b0);
      wait_result("random", $urandom_range(0, 2));
    end

    // Two-nibble build.
    run2(8'hFF, 8'h01, 1'b1);
    for (int n = 0; n < 8; n++) begin
      run2(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand (legal range 2..8).
REQ-002 The block SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  operands A, B, Cin presented.
REQ-005 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-006 The block SHALL have port A  input  4*NIBBLES  operand A, unsigned.
REQ-007 The block SHALL have port B  input  4*NIBBLES  operand B, unsigned.
REQ-008 The block SHALL have port Cin  input  1  carry-in to the least significant nibble.
REQ-009 The block SHALL have port out_valid  output  1  Sum holds a completed result.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts Sum.
REQ-011 The block SHALL have port Sum  output  4*NIBBLES+1  result, where the MSB is the final carry-out.
REQ-012 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, and in_ready SHALL equal (state==IDLE).
REQ-014 Accept SHALL occur on an edge with in_valid&&in_ready, which registers A, B and Cin, clears Sum, sets nibble counter cnt=0, sets carry register c=Cin and enters RUN.
REQ-015 Each RUN edge SHALL write Sum[4*cnt+3:4*cnt] = A_nib[cnt]+B_nib[cnt]+c (low 4 bits), set c to the carry-out and increment cnt.
REQ-016 The RUN edge with cnt==NIBBLES-1 SHALL also write Sum[4*NIBBLES]=carry-out and move the FSM to DONE.
REQ-017 Latency SHALL be exactly NIBBLES cycles: out_valid rises NIBBLES edges after the accept edge.
REQ-018 out_valid SHALL equal (state==DONE), and Sum SHALL stay stable while out_valid is high.
REQ-019 In DONE with out_ready high, the FSM SHALL return to IDLE on that edge; in DONE with out_ready low, it SHALL hold indefinitely.
REQ-020 in_valid, A, B and Cin SHALL be ignored outside IDLE; there SHALL be no overlap between operations and no queueing.
REQ-021 The earliest back-to-back accept SHALL be on the edge after the DONE->IDLE edge, giving a throughput of one result per NIBBLES+2 cycles with out_ready held high.
REQ-022 Arithmetic SHALL be unsigned modulo-free: Sum = A+B+Cin exactly, in 4*NIBBLES+1 bits.
REQ-023 cnt SHALL be ceil(log2(NIBBLES)) bits wide and SHALL never exceed NIBBLES-1.

Reset
REQ-024 Assertion of rst SHALL immediately force state=IDLE, cnt=0, c=0, Sum=0, out_valid=0, busy=0 and in_ready=1, independent of clk.
REQ-025 Reset mid-RUN or in DONE SHALL discard the operation, and no partial result SHALL be presented.
REQ-026 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 The block SHALL instantiate one sub-module nibble_adder (4-bit combinational ripple adder built from full-adder cells: inputs a[3:0], b[3:0], ci; outputs s[3:0], co), reused every RUN cycle.
REQ-028 A shared package adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the constant NIB_W=4.
REQ-029 Nibble selection SHALL use indexed part-selects driven by cnt, with no per-nibble duplicated logic.

Verification
REQ-030 The bench SHALL cover: A=0x00FF, B=0x0001, Cin=0, accepted at edge k -> Sum=0x00100 with out_valid first high at edge k+4.
REQ-031 The bench SHALL cover: A=0xFFFF, B=0xFFFF, Cin=1 -> Sum=0x1FFFF, with carry propagating through all nibbles.
REQ-032 The bench SHALL cover: A=0x1234, B=0x4321, Cin=0, out_ready low for 5 cycles after out_valid -> Sum=0x05555 held stable, busy=1, in_ready=0, and the FSM returns to IDLE on the edge out_ready rises.
REQ-033 The bench SHALL cover: in_valid held high during RUN with A=0xAAAA, B=0x5555 -> ignored; the first result is unchanged and the second operation is accepted only after DONE->IDLE.
REQ-034 The bench SHALL cover: rst pulsed at RUN cnt=2 -> Sum=0, out_valid=0, in_ready=1 immediately, and a following 0x0001+0x0001 yields 0x00002 after 4 cycles.
REQ-035 The bench SHALL cover: NIBBLES=2 build, A=0xFF, B=0x01, Cin=1 -> Sum=0x101 with a latency of 2 cycles.
